// File: rtl/beacon_pkg.sv
// ============================================================================
//  Module      : beacon_pkg
//  Description : Shared widths, sweep state encoding and default dwell length
//                for the beacon peak-search sweep controller.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package beacon_pkg;

  // Correlator code-shift and match-count widths
  localparam int SHIFT_W = 8;
  localparam int VALUE_W = 8;

  // Dwell long enough for one partial plus one full 256-chip window
  localparam int DWELL_CYCLES_DEF = 512;

  // Sweep controller states
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_DWELL  = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/peak_search_dwell_timer.sv
// ============================================================================
//  Module      : dwell_timer
//  Description : Loadable down-counter with a zero flag. Loaded with
//                DWELL_CYCLES-1, so counting down to zero with i_en held
//                spans exactly DWELL_CYCLES cycles.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                i_load - load DWELL_CYCLES-1 (has priority over i_en)
//                i_en   - decrement, saturating at zero
//                o_zero - counter is zero
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module dwell_timer
  import beacon_pkg::*;
#(
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_zero
);

  localparam int               CNT_W      = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] C_LOAD_VAL = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= C_LOAD_VAL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/peak_search.sv
// ============================================================================
//  Module      : peak_search
//  Description : Sweeps the beacon correlator code shift from SHIFT_FIRST to
//                SHIFT_LAST in STEP increments. For each shift the correlator
//                is held in reset for one LOAD cycle, released for
//                DWELL_CYCLES, then its match count is sampled. At sweep end
//                the highest count (lowest shift on ties) is reported along
//                with a lock flag against the threshold captured at start.
//  Ports       : clk, rst_n  - clock, asynchronous active-low reset
//                start       - begin a sweep (IDLE only)
//                threshold   - lock threshold, captured on accepted start
//                corr_value  - correlator match count
//                corr_rst    - correlator reset (active-high)
//                corr_shift  - correlator code shift
//                busy        - sweep in progress
//                done        - one-cycle pulse at sweep end
//                locked      - best_value >= captured threshold
//                best_shift  - winning shift
//                best_value  - winning count
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module peak_search
  import beacon_pkg::*;
#(
  parameter int SHIFT_FIRST  = 0,
  parameter int SHIFT_LAST   = 255,
  parameter int STEP         = 1,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [VALUE_W-1:0] threshold,
  input  logic [VALUE_W-1:0] corr_value,
  output logic               corr_rst,
  output logic [SHIFT_W-1:0] corr_shift,
  output logic               busy,
  output logic               done,
  output logic               locked,
  output logic [SHIFT_W-1:0] best_shift,
  output logic [VALUE_W-1:0] best_value
);

  localparam logic [SHIFT_W-1:0] C_FIRST = SHIFT_W'(SHIFT_FIRST);
  localparam logic [SHIFT_W-1:0] C_STEP  = SHIFT_W'(STEP);
  localparam logic [SHIFT_W:0]   C_STEP9 = (SHIFT_W + 1)'(STEP);
  localparam logic [SHIFT_W:0]   C_LAST9 = (SHIFT_W + 1)'(SHIFT_LAST);

  state_t             r_state;
  state_t             w_state_nxt;

  logic [SHIFT_W-1:0] r_cur_shift;
  logic [VALUE_W-1:0] r_thresh;
  logic [VALUE_W-1:0] r_run_value;
  logic [SHIFT_W-1:0] r_run_shift;
  logic [SHIFT_W-1:0] r_best_shift;
  logic [VALUE_W-1:0] r_best_value;
  logic               r_locked;

  logic               w_dwell_zero;
  logic               w_better;
  logic               w_last_shift;
  logic [VALUE_W-1:0] w_run_value_nxt;
  logic [SHIFT_W-1:0] w_run_shift_nxt;

  // --------------------------------------------------------------------------
  // Dwell counter
  // --------------------------------------------------------------------------
  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES)
  ) u_dwell_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (r_state == S_LOAD),
    .i_en   (r_state == S_DWELL),
    .o_zero (w_dwell_zero)
  );

  // --------------------------------------------------------------------------
  // Running-best comparator. Strictly-greater keeps the lower shift on ties.
  // The end-of-sweep test is done one bit wider so the shift never wraps.
  // --------------------------------------------------------------------------
  assign w_better        = (corr_value > r_run_value);
  assign w_run_value_nxt = w_better ? corr_value  : r_run_value;
  assign w_run_shift_nxt = w_better ? r_cur_shift : r_run_shift;
  assign w_last_shift    = (({1'b0, r_cur_shift} + C_STEP9) > C_LAST9);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LOAD;
      S_LOAD:   w_state_nxt = S_DWELL;
      S_DWELL:  if (w_dwell_zero) w_state_nxt = S_SAMPLE;
      S_SAMPLE: w_state_nxt = w_last_shift ? S_DONE : S_LOAD;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    corr_rst = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_LOAD:   busy = 1'b1;
      S_DWELL,
      S_SAMPLE: begin
        busy     = 1'b1;
        corr_rst = 1'b0;
      end
      S_DONE:   done = 1'b1;
      default:  ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sweep datapath and result registers. The results are written on the
  // edge that enters DONE (folding in the final sample) so they are already
  // valid in the cycle where done is high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_shift  <= '0;
      r_thresh     <= '0;
      r_run_value  <= '0;
      r_run_shift  <= '0;
      r_best_shift <= '0;
      r_best_value <= '0;
      r_locked     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_thresh    <= threshold;
            r_cur_shift <= C_FIRST;
            r_run_value <= '0;
            r_run_shift <= C_FIRST;
          end
        end
        S_SAMPLE: begin
          r_run_value <= w_run_value_nxt;
          r_run_shift <= w_run_shift_nxt;
          if (w_last_shift) begin
            r_best_value <= w_run_value_nxt;
            r_best_shift <= w_run_shift_nxt;
            r_locked     <= (w_run_value_nxt >= r_thresh);
          end else begin
            r_cur_shift  <= r_cur_shift + C_STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign corr_shift = r_cur_shift;
  assign best_shift = r_best_shift;
  assign best_value = r_best_value;
  assign locked     = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_peak_search.sv
// ============================================================================
//  Module      : tb_peak_search
//  Description : Self-checking bench for peak_search. A behavioural
//                correlator returns a per-shift table value only once a full
//                window has elapsed after release; expected results come
//                from a direct scan of the visited shifts in that table.
//  Revision    : 1.0  - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_peak_search;

  localparam int SF  = 10;
  localparam int SL  = 250;
  localparam int ST  = 16;
  localparam int DW  = 512;
  localparam int NSH = (SL - SF) / ST + 1;
  localparam int PER = DW + 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       start     = 1'b0;
  logic [7:0] threshold = 8'd0;
  logic [7:0] corr_value;
  logic       corr_rst;
  logic [7:0] corr_shift;
  logic       busy;
  logic       done;
  logic       locked;
  logic [7:0] best_shift;
  logic [7:0] best_value;

  always #5 clk = ~clk;

  peak_search #(
    .SHIFT_FIRST  (SF),
    .SHIFT_LAST   (SL),
    .STEP         (ST),
    .DWELL_CYCLES (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .threshold  (threshold),
    .corr_value (corr_value),
    .corr_rst   (corr_rst),
    .corr_shift (corr_shift),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .best_shift (best_shift),
    .best_value (best_value)
  );

  // Behavioural correlator: output is only meaningful after a full window
  logic [7:0] corr_tab [256];
  int         rel_cnt = 0;
  always @(posedge clk) rel_cnt <= corr_rst ? 0 : rel_cnt + 1;
  assign corr_value = (!corr_rst && rel_cnt >= DW) ? corr_tab[corr_shift] : 8'd0;

  // Monitor: shift at every LOAD cycle, and shift stability while released
  int loads[$];
  int last_load = 0;
  int stab_err  = 0;
  always @(negedge clk) begin
    if (busy && corr_rst) begin
      loads.push_back(int'(corr_shift));
      last_load = int'(corr_shift);
    end else if (busy && int'(corr_shift) != last_load) begin
      stab_err++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int prev_v   = 0;
  int prev_s   = 0;
  int prev_l   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int maxv);
    for (int s = 0; s < 256; s++) corr_tab[s] = 8'($urandom_range(maxv, 0));
  endtask

  task automatic check_held(input string name);
    check_eq($sformatf("%s.held_value", name), best_value, prev_v);
    check_eq($sformatf("%s.held_shift", name), best_shift, prev_s);
    check_eq($sformatf("%s.held_locked", name), locked, prev_l);
  endtask

  // Full sweep from IDLE (caller at a falling edge). poke pulses start
  // mid-sweep, which must be ignored.
  task automatic run_sweep(input string name, input logic [7:0] thr, input bit poke);
    int ev, es, lb, se0, lat, errs;
    bit lk, got;
    ev = 0;
    es = SF;
    for (int s = SF; s <= SL; s += ST) begin
      if (int'(corr_tab[s]) > ev) begin
        ev = int'(corr_tab[s]);
        es = s;
      end
    end
    lk  = (ev >= int'(thr));
    lb  = loads.size();
    se0 = stab_err;

    threshold = thr;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    threshold = ~thr;
    check_eq($sformatf("%s.busy_rise", name), busy, 1);

    got = 1'b0;
    lat = 0;
    for (int i = 0; i <= NSH * PER + 16; i++) begin
      if (done) begin
        got = 1'b1;
        lat = i;
        break;
      end
      if (i == 1000 && poke) start = 1'b1;
      if (i == 1001) start = 1'b0;
      if (i == 2000) check_held(name);
      @(negedge clk);
    end
    check_eq($sformatf("%s.done_seen", name), got, 1);
    check_eq($sformatf("%s.done_latency", name), lat, NSH * PER);
    check_eq($sformatf("%s.best_shift", name), best_shift, es);
    check_eq($sformatf("%s.best_value", name), best_value, ev);
    check_eq($sformatf("%s.locked", name), locked, lk);
    check_eq($sformatf("%s.busy_at_done", name), busy, 0);
    check_eq($sformatf("%s.corr_rst_at_done", name), corr_rst, 1);

    errs = 0;
    for (int k = 0; k < NSH; k++) begin
      if (lb + k >= loads.size() || loads[lb + k] != SF + k * ST) errs++;
    end
    check_eq($sformatf("%s.n_loads", name), loads.size() - lb, NSH);
    check_eq($sformatf("%s.shift_seq_err", name), errs, 0);
    check_eq($sformatf("%s.shift_unstable", name), stab_err - se0, 0);

    // start during DONE is ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq($sformatf("%s.done_pulse_len", name), done, 0);
    check_eq($sformatf("%s.start_in_done", name), busy, 0);
    prev_v = ev;
    prev_s = es;
    prev_l = int'(lk);
    check_held(name);
    @(negedge clk);
    check_eq($sformatf("%s.idle_after", name), busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    bit got;
    for (int s = 0; s < 256; s++) corr_tab[s] = 8'd0;

    // Reset, with start pulsed while in reset
    start = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst.corr_rst", corr_rst, 1);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.locked", locked, 0);
    check_eq("rst.best_shift", best_shift, 0);
    check_eq("rst.best_value", best_value, 0);
    check_eq("rst.corr_shift", corr_shift, 0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst.no_activity", busy, 0);

    // Single peak above threshold
    fill(150);
    corr_tab[42] = 8'd200;
    run_sweep("peak", 8'd150, 1'b1);

    // Tie: lower shift wins
    fill(150);
    corr_tab[42]  = 8'd200;
    corr_tab[170] = 8'd200;
    run_sweep("tie", 8'($urandom_range(255, 0)), 1'b0);

    // Below threshold
    fill(100);
    corr_tab[26] = 8'd120;
    run_sweep("below", 8'd150, 1'b1);

    // Peak at the final shift, value exactly equal to threshold
    fill(254);
    corr_tab[250] = 8'd255;
    run_sweep("last_eq", 8'd255, 1'b0);

    // Abort during DWELL of shift 106
    fill(150);
    threshold = 8'd50;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got   = 1'b0;
    for (int i = 0; i < NSH * PER; i++) begin
      if (busy && !corr_rst && corr_shift == 8'd106) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("abort.reach_shift", got, 1);
    repeat (100) @(negedge clk);
    check_eq("abort.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("abort.corr_rst", corr_rst, 1);
    check_eq("abort.busy", busy, 0);
    check_eq("abort.locked", locked, 0);
    check_eq("abort.best_value", best_value, 0);
    check_eq("abort.best_shift", best_shift, 0);
    check_eq("abort.corr_shift", corr_shift, 0);
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check_eq("abort.no_done", dn, 0);
    prev_v = 0;
    prev_s = 0;
    prev_l = 0;

    // Restart after abort: all-zero sweep with zero threshold
    fill(0);
    run_sweep("zero", 8'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/peak_search.md
# peak_search

Sweep controller downstream of the beacon correlator. It steps the correlator's code shift across a configured range and holds the correlator in reset while it loads each shift. It dwells long enough for a full, clean correlation window, then samples the correlator's 8-bit match count. At the end of the sweep it reports the shift with the highest count and whether that count clears a lock threshold.

## Interface
Parameters:
- SHIFT_FIRST, 0: first shift visited.
- SHIFT_LAST, 255: last shift visited. (SHIFT_LAST − SHIFT_FIRST) must be a multiple of STEP.
- STEP, 1: shift increment, 1..255.
- DWELL_CYCLES, 512: cycles with correlator released before sampling. Must be ≥ 2 × 256, so one partial and one full window complete.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin sweep; honoured only in IDLE.
- threshold  in  8  lock threshold; captured on accepted start.
- corr_value  in  8  correlator match count.
- corr_rst  out  1  correlator reset, active-high.
- corr_shift  out  8  correlator shift.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- locked  out  1  best_value ≥ captured threshold; valid from done.
- best_shift  out  8  winning shift; valid from done.
- best_value  out  8  winning count; valid from done.

## Operation
- States: IDLE, LOAD, DWELL, SAMPLE, DONE.
- IDLE: corr_rst=1 and busy=0. When start=1:
  - capture threshold;
  - set cur_shift=SHIFT_FIRST, run_best_value=0, run_best_shift=SHIFT_FIRST;
  - go to LOAD.
- LOAD: lasts 1 cycle. corr_rst=1, corr_shift=cur_shift, busy=1. Load the dwell counter with DWELL_CYCLES−1, then go to DWELL.
- DWELL: corr_rst=0, corr_shift held. Decrement the counter each cycle. Go to SAMPLE when the counter is 0, so DWELL lasts exactly DWELL_CYCLES cycles.
- SAMPLE: lasts 1 cycle, corr_rst=0.
  - If corr_value > run_best_value (strictly greater), update run_best_value and run_best_shift. Ties keep the lower shift.
  - Go to DONE if cur_shift + STEP > SHIFT_LAST; compare in 9 bits so the shift never wraps.
  - Otherwise cur_shift += STEP and go to LOAD.
- DONE: lasts 1 cycle.
  - done=1, busy=0, corr_rst=1.
  - best_shift/best_value ← running values; locked ← (run_best_value ≥ threshold).
  - Go to IDLE.
- Result outputs change only in DONE and hold until the next DONE or reset.
- start in any state other than IDLE is ignored, including DONE. threshold changes after capture have no effect.
- All-zero sweep: best_value=0, best_shift=SHIFT_FIRST, and locked=(threshold==0).

## Timing
- Reset values (async, on rst_n=0): state=IDLE, corr_rst=1, corr_shift=0, busy=0, done=0, locked=0, best_shift=0, best_value=0. Counters and running registers are cleared.
- rst_n low mid-sweep aborts immediately: no done, and results are cleared. Start is first honoured on the first rising edge with rst_n high.
- Edge with start=1 in IDLE → LOAD on the next cycle; busy rises together with LOAD.
- Per shift: 1 (LOAD) + DWELL_CYCLES + 1 (SAMPLE) cycles. For N = (SHIFT_LAST−SHIFT_FIRST)/STEP + 1 shifts, done asserts N×(DWELL_CYCLES+2) cycles after LOAD is first entered.
- Defaults: N=256, done is 131584 cycles after first LOAD.
- corr_value is sampled registered, in the SAMPLE cycle only.
- corr_shift is stable throughout LOAD+DWELL+SAMPLE.

## Structure
- Package beacon_pkg:
  - SHIFT_W=8 and VALUE_W=8;
  - state enum;
  - default DWELL_CYCLES.
- One sub-module, dwell_timer: loadable down-counter with a zero flag, width from $clog2(DWELL_CYCLES).
- The FSM, running-best comparator and result registers stay in peak_search.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset: hold rst_n=0 → corr_rst=1, busy=0, done=0, locked=0, best_shift=0, best_value=0. Pulse start with rst_n=0 → no activity.
- Single peak, defaults: behavioural correlator returns 200 at shift 37 and 100 elsewhere; threshold=150 → done after 131584 cycles, best_shift=37, best_value=200, locked=1, busy falls with done.
- Tie: 200 at shifts 37 and 90 → best_shift=37.
- Below threshold: peak 120 at shift 5; threshold=150 → best_shift=5, best_value=120, locked=0.
- Abort and restart: rst_n pulsed low during DWELL of shift 100 → outputs at reset values with no done. A start pulsed while busy is ignored; a new start sweeps again from shift 0.
- Parameters SHIFT_FIRST=10, SHIFT_LAST=250, STEP=16, DWELL_CYCLES=512 → corr_shift visits 10, 26, …, 250 (16 shifts, no wrap past 255), and done arrives 16×514 cycles after first LOAD.
